// File: rtl/divider_radix2.sv
// divider_radix2: iterative 32-bit signed/unsigned restoring divider for the
// execute stage. Produces one quotient bit per cycle and returns
// {remainder, quotient} for the HI/LO path. Holds the pipeline via div_stall.

module divider_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_ex,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        valid,
  input  logic        sign,
  output logic        div_stall,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] divisor;
  logic [4:0]  count;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [33:0] shifted;
  logic [33:0] trial;
  logic [32:0] next_rem;
  logic [31:0] next_quo;
  logic [31:0] fix_quo;
  logic [31:0] fix_rem;

  // Operand magnitudes: signed divides work on absolute values and fix signs at the end
  always_comb begin
    a_mag = (sign && a[31]) ? (~a + 32'd1) : a;
    b_mag = (sign && b[31]) ? (~b + 32'd1) : b;
  end

  // One restoring iteration plus the sign fix-up applied on the final iteration
  always_comb begin
    shifted = {rem, quo[31]};
    trial   = shifted - {2'b00, divisor};
    if (!trial[33]) begin
      next_rem = trial[32:0];
      next_quo = {quo[30:0], 1'b1};
    end else begin
      next_rem = shifted[32:0];
      next_quo = {quo[30:0], 1'b0};
    end
    fix_quo = neg_q ? (~next_quo + 32'd1) : next_quo;
    fix_rem = neg_r ? (~next_rem[31:0] + 32'd1) : next_rem[31:0];
  end

  // Stall the pipeline while a live divide has not yet reached DONE
  assign div_stall = ~rst & valid & ~flush & (state != DONE);

  // Control FSM and datapath registers; reset beats flush, flush beats everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rem     <= 33'd0;
      quo     <= 32'd0;
      divisor <= 32'd0;
      count   <= 5'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= 64'd0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            neg_q <= sign & (a[31] ^ b[31]);
            neg_r <= sign & a[31];
            if (b == 32'd0) begin
              result <= {a, 32'hFFFF_FFFF};
              state  <= DONE;
            end else begin
              rem     <= 33'd0;
              quo     <= a_mag;
              divisor <= b_mag;
              count   <= 5'd0;
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          rem   <= next_rem;
          quo   <= next_quo;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            result <= {fix_rem, fix_quo};
            state  <= DONE;
          end
        end
        DONE: begin
          if (!stall_ex) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_radix2.sv
// tb_divider_radix2: directed and randomized checks of divider_radix2 against
// an arithmetic reference model (plain / and % on wide integers).

module tb_divider_radix2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        stall_ex;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid;
  logic        sign;
  logic        div_stall;
  logic [63:0] result;

  int checks;
  int errors;

  divider_radix2 dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall_ex  (stall_ex),
    .a         (a),
    .b         (b),
    .valid     (valid),
    .sign      (sign),
    .div_stall (div_stall),
    .result    (result)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: HI = remainder, LO = quotient, computed with plain arithmetic
  function automatic logic [63:0] refDiv(input logic [31:0] x, input logic [31:0] y,
                                         input logic s);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [31:0] uq;
    logic [31:0] ur;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (!s) begin
      uq = x / y;
      ur = x % y;
      return {ur, uq};
    end
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = sx / sy;
    r  = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Present a divide at a negedge and run until div_stall drops (bounded);
  // returns in the first non-stalled cycle, sampled 1 time unit after negedge
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic s,
                               output int stall_cycles);
    a     = x;
    b     = y;
    sign  = s;
    valid = 1'b1;
    #1;
    stall_cycles = 0;
    while (div_stall && stall_cycles < 100) begin
      stall_cycles++;
      @(negedge clk);
      #1;
    end
  endtask

  // Full divide with checks on stall length and result value
  task automatic runDivide(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic s);
    int n;
    applyStimulus(x, y, s, n);
    checkOutput({tag, "_stall"}, 64'(n), (y == 32'd0) ? 64'd1 : 64'd33);
    checkOutput({tag, "_result"}, result, refDiv(x, y, s));
  endtask

  initial begin
    int          n;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [63:0] held;

    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    stall_ex = 1'b0;
    valid    = 1'b1;
    sign     = 1'b0;
    a        = 32'd100;
    b        = 32'd7;

    // Reset state, with valid high to confirm reset masks div_stall
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_stall", 64'(div_stall), 64'd0);
    checkOutput("rst_result", result, 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    #1;
    checkOutput("post_rst_stall", 64'(div_stall), 64'd0);
    checkOutput("post_rst_result", result, 64'd0);

    // Directed divides from the test plan
    @(negedge clk);
    applyStimulus(32'd100, 32'd7, 1'b0, n);
    checkOutput("u100_7_stall", 64'(n), 64'd33);
    checkOutput("u100_7_result", result, 64'h00000002_0000000E);
    @(negedge clk);
    valid = 1'b0;
    #1;
    checkOutput("u100_7_idle_stall", 64'(div_stall), 64'd0);

    @(negedge clk);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, n);
    checkOutput("s_m7_2", result, 64'hFFFFFFFF_FFFFFFFD);
    @(negedge clk);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, n);
    checkOutput("s_7_m2", result, 64'h00000001_FFFFFFFD);
    @(negedge clk);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, n);
    checkOutput("u_max_1", result, 64'h00000000_FFFFFFFF);
    @(negedge clk);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, n);
    checkOutput("s_min_m1", result, 64'h00000000_80000000);
    checkOutput("s_min_m1_stall", 64'(n), 64'd33);

    // Divide by zero
    @(negedge clk);
    applyStimulus(32'h1234_5678, 32'd0, 1'b1, n);
    checkOutput("div0_stall", 64'(n), 64'd1);
    checkOutput("div0_result", result, 64'h12345678_FFFFFFFF);
    held = 64'h12345678_FFFFFFFF;

    // Flush at cycle 10
    @(negedge clk);
    a     = 32'd1000;
    b     = 32'd3;
    sign  = 1'b0;
    valid = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("flush_pre_stall", 64'(div_stall), 64'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush_stall", 64'(div_stall), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    valid = 1'b0;
    #1;
    checkOutput("flush_idle_stall", 64'(div_stall), 64'd0);
    checkOutput("flush_result_held", result, held);
    @(negedge clk);
    runDivide("after_flush", 32'd1000, 32'd3, 1'b0);

    // stall_ex held for 3 cycles in DONE, then an immediate second divide
    @(negedge clk);
    applyStimulus(32'hDEAD_BEEF, 32'd12345, 1'b0, n);
    held = refDiv(32'hDEAD_BEEF, 32'd12345, 1'b0);
    checkOutput("stallex_first", result, held);
    stall_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) stall_ex = 1'b0;
      #1;
      checkOutput($sformatf("stallex_hold%0d", i), result, held);
      checkOutput($sformatf("stallex_nostall%0d", i), 64'(div_stall), 64'd0);
    end
    @(negedge clk);
    runDivide("stallex_second", 32'hFFFF_F000, 32'd77, 1'b1);

    // Reset at cycle 10 of a divide
    @(negedge clk);
    a     = 32'd999;
    b     = 32'd4;
    sign  = 1'b0;
    valid = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("midrst_result", result, 64'd0);
    checkOutput("midrst_stall", 64'(div_stall), 64'd0);
    rst   = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midrst_after", result, 64'd0);

    // Randomized divides, some back-to-back, some with an idle gap
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      valid = 1'b0;
      if ($urandom_range(0, 1) == 0) begin
        @(negedge clk);
      end
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 16);
        2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 16);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      rs = 1'($urandom_range(0, 1));
      runDivide($sformatf("rand%0d", k), ra, rb, rs);
    end

    @(negedge clk);
    valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_radix2.md
# divider_radix2

Iterative 32-bit signed/unsigned divider for the execute stage, fed directly by the ALU operand path for DIV/DIVU. It computes one quotient bit per cycle with a restoring radix-2 algorithm. It holds the pipeline through `div_stall` while busy, and returns `{remainder, quotient}` as a 64-bit word the HI/LO path consumes unchanged (HI = remainder, LO = quotient).

## Interface
- No parameters; operand width fixed at 32, result 64.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `flush` in 1: cancel any in-flight division (execute-stage flush).
- `stall_ex` in 1: execute stage held by another source; result must be held.
- `a` in 32: dividend (rs).
- `b` in 32: divisor (rt).
- `valid` in 1: a divide instruction occupies execute; held high while it remains there.
- `sign` in 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with operands.
- `div_stall` out 1: pipeline must hold execute and earlier stages.
- `result` out 64: `{remainder[31:0], quotient[31:0]}`; valid when `state==DONE`.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE:**
  - If `valid & ~flush`, latch the operands at the edge:
    - `|a|` and `|b|` when `sign`, raw values otherwise.
    - `neg_q = sign & (a[31]^b[31])` and `neg_r = sign & a[31]`.
  - If `b==0`, go to DONE with `result = {a, 32'hFFFFFFFF}`, without sign fix-up.
  - Otherwise go to BUSY with `count=0`, a 33-bit partial remainder of 0, and the quotient register loaded with the dividend magnitude.
- **BUSY**, each cycle:
  - Shift `{rem, quo}` left 1.
  - Compute the trial difference `rem_shifted - divisor`.
  - If it is non-negative, keep the difference and set quotient bit 0 to 1; otherwise restore and set the bit to 0.
  - Increment `count`.
  - After the iteration with `count==31`, go to DONE. Register `result` with the quotient negated if `neg_q` and the remainder negated if `neg_r` (two's complement, 32-bit wrap).
- **DONE:**
  - `result` is stable.
  - If `stall_ex`, stay in DONE and keep `result` held.
  - Otherwise go to IDLE at the next edge; the pipeline advances on that same edge.
- **`div_stall`** is combinational: `valid & ~flush & (state != DONE)`.
- **Boundary cases:**
  - Signed `0x80000000 / 0xFFFFFFFF` gives quotient `0x80000000`, remainder 0 (wraps, no trap).
  - Unsigned divides with MSB set are handled by the 33-bit remainder.
  - A back-to-back divide arrives in IDLE with `valid` high and starts normally.
  - `valid` dropping while BUSY is not a legal stimulus; `flush` is the only abort.
- **Flush:** `flush` in any state forces IDLE at the next edge. `result` keeps its last value, and no DONE cycle is produced.
- **Reset:** `rst` has priority over `flush` and `valid`. It sets state IDLE, count 0, `result` 0, and all internal registers 0. `div_stall` is 0 while `rst` is high.

## Timing
- Let cycle 0 be the cycle in which `valid` is first high in IDLE.
- Normal divide:
  - `div_stall` is high in cycles 0..32.
  - State is BUSY in cycles 1..32 (32 iterations) and DONE in cycle 33.
  - `div_stall` is low in cycle 33 and `result` is valid there; the instruction leaves execute at the end of cycle 33.
- Divide by zero: `div_stall` is high in cycle 0 only; DONE is in cycle 1.
- `stall_ex` high in DONE extends DONE one cycle per stalled cycle, with `div_stall` kept low.
- Reset mid-BUSY: IDLE at the next edge, and `result` reads 0 from the following cycle.
- Outputs after reset: `div_stall` is 0 (given `valid` low or reset held) and `result` is 64'h0.

## Test plan
- Unsigned 100 / 7:
  - `div_stall` is high for exactly 33 cycles.
  - Cycle 33: `result = 64'h00000002_0000000E`.
  - Returns to IDLE next cycle.
- Signed -7 / 2 (`a=32'hFFFFFFF9`, `b=2`, `sign=1`): `result = 64'hFFFFFFFF_FFFFFFFD`. Also signed 7 / -2: `result = 64'h00000001_FFFFFFFD`.
- Edge operands:
  - DIVU `32'hFFFFFFFF / 1` gives `64'h00000000_FFFFFFFF`.
  - DIV `32'h80000000 / 32'hFFFFFFFF` gives `64'h00000000_80000000`.
- Divide by zero, `a=32'h12345678`, `b=0`:
  - `div_stall` is high 1 cycle.
  - Cycle 1: `result = 64'h12345678_FFFFFFFF`.
- Control events:
  - `flush` at cycle 10: IDLE next edge, `div_stall` low, `result` unchanged, and a following divide completes correctly.
  - `rst` at cycle 10: `result = 0`.
- `stall_ex` high for 3 cycles at DONE:
  - `result` is held for 4 cycles with `div_stall` low.
  - A second divide presented immediately afterward starts in IDLE and completes 33 cycles later with correct value.
